// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if - CSR bus bundle shared by the register blocks.
//
// Signals:
//   csr_a   5-bit CSR address, driven by the bus master
//   csr_di  8-bit write data, driven by the bus master
//   csr_we  single-cycle write strobe, driven by the bus master
//   csr_do  8-bit read data from the slave, 8'h00 outside its window
//
// Transfer rule: there is no valid/ready pair on this bus. A write is
// accepted unconditionally on the rising clk edge where csr_we = 1, using the
// csr_a/csr_di present in that cycle. Reads have no strobe: csr_do is a
// combinational function of csr_a and the slave's current register state, so
// the slave never stalls the master.
interface irq_ctrl_if;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (
        output csr_a,
        output csr_di,
        output csr_we,
        input  csr_do
    );

    modport slave (
        input  csr_a,
        input  csr_di,
        input  csr_we,
        output csr_do
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl - interrupt controller and sequencer for the shared
// CPLD_INTERRUPT_CFG_RCW_SRC2 pin.
//
// Collects up to eight synchronous sources into a pending (STATUS) register
// with per-source MASK and TYPE (level / rising edge), combines them under a
// global enable into a registered irq, and drives that onto a pin which also
// carries the RCW_SRC2 strap while reset strap sampling is in progress.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   csr          CSR bus (irq_ctrl_if slave): csr_a, csr_di, csr_we, csr_do
//   irq_in       source requests, synchronous to clk, active high
//   strap_hold   high while the pin must stay in its strap phase
//   pin_oe       pin output enable (registered)
//   pin_out      pin output value (registered)
//   irq          combined request, active high (registered)
//   dbg_state_o  current pin-sequencer state (0 STRAP, 1 HOLDOFF, 2 ACTIVE)
//
// Register map (BASE_ADDR relative):
//   +0 STATUS  pending bits, write 1 to clear; a same-cycle set wins
//   +1 MASK    1 = source enabled
//   +2 TYPE    0 = level, 1 = rising edge
//   +3 CTRL    bit0 GEN, bit1 POL (active-low pin), bit2 OD (open drain)
module irq_ctrl #(
    parameter logic [4:0] BASE_ADDR      = 5'h1c,
    parameter int         NUM_IRQS       = 8,
    parameter int         HOLDOFF_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    irq_ctrl_if.slave           csr,
    input  logic [NUM_IRQS-1:0] irq_in,
    input  logic                strap_hold,
    output logic                pin_oe,
    output logic                pin_out,
    output logic                irq,
    output logic [1:0]          dbg_state_o
);

    // Register bits at index NUM_IRQS and above never latch and read 0.
    localparam logic [7:0] IMPL_MASK = 8'((9'd1 << NUM_IRQS) - 9'd1);
    localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STRAP   = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_ACTIVE  = 2'd2
    } pin_state_e;

    logic [7:0] status_q, status_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] type_q, type_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic [7:0] prev_q, prev_d;
    logic       irq_q, irq_d;

    pin_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pin_oe_q, pin_oe_d;
    logic       pin_out_q, pin_out_d;

    logic [7:0] irq_in_ext;
    logic [7:0] set_vec;
    logic [7:0] w1c_vec;
    logic [5:0] addr_ext;
    logic       hit;
    logic [1:0] offs;
    logic       wr_status, wr_mask, wr_type, wr_ctrl;

    assign irq_in_ext = 8'(irq_in) & IMPL_MASK;

    // Compare with one extra bit so BASE+4 wrapping past 5'h1f does not alias
    // back into the window.
    assign addr_ext = {1'b0, csr.csr_a};
    assign hit      = (addr_ext >= {1'b0, BASE_ADDR}) &&
                      (addr_ext <  ({1'b0, BASE_ADDR} + 6'd4));
    assign offs     = 2'(csr.csr_a - BASE_ADDR);

    assign wr_status = csr.csr_we && hit && (offs == 2'd0);
    assign wr_mask   = csr.csr_we && hit && (offs == 2'd1);
    assign wr_type   = csr.csr_we && hit && (offs == 2'd2);
    assign wr_ctrl   = csr.csr_we && hit && (offs == 2'd3);

    // Level sources fire whenever high; edge sources only when the previous
    // sample was low. Equivalent to in & ~(type & prev).
    assign set_vec = irq_in_ext & ~(type_q & prev_q);
    assign w1c_vec = wr_status ? csr.csr_di : 8'h00;

    always_comb begin
        // Set is ORed in after the clear so a coincident set keeps the bit.
        status_d = ((status_q & ~w1c_vec) | set_vec) & IMPL_MASK;
        mask_d   = wr_mask ? (csr.csr_di & IMPL_MASK) : mask_q;
        type_d   = wr_type ? (csr.csr_di & IMPL_MASK) : type_q;
        ctrl_d   = wr_ctrl ? csr.csr_di[2:0] : ctrl_q;
        prev_d   = irq_in_ext;
        irq_d    = ctrl_q[0] && ((status_q & mask_q) != 8'h00);
    end

    // Pin sequencer: next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STRAP: begin
                if (!strap_hold) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLDOFF_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (strap_hold) begin
                    state_d = ST_STRAP;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (strap_hold) begin
                    state_d = ST_STRAP;
                end
            end
            default: begin
                state_d = ST_STRAP;
            end
        endcase
    end

    // Pin outputs are registered and decoded from the state being entered,
    // so the pin changes on the same edge as the state.
    always_comb begin
        pin_oe_d  = 1'b1;
        pin_out_d = 1'b0;
        case (state_d)
            ST_STRAP: begin
                pin_oe_d  = 1'b1;
                pin_out_d = 1'b0;
            end
            ST_HOLDOFF: begin
                pin_oe_d  = 1'b0;
                pin_out_d = 1'b0;
            end
            ST_ACTIVE: begin
                if (ctrl_q[2]) begin
                    // Open drain: enable only while asserted, output the
                    // asserted level.
                    pin_oe_d  = irq_q;
                    pin_out_d = ~ctrl_q[1];
                end else begin
                    pin_oe_d  = 1'b1;
                    pin_out_d = irq_q ^ ctrl_q[1];
                end
            end
            default: begin
                pin_oe_d  = 1'b1;
                pin_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= 8'h00;
            mask_q    <= 8'h00;
            type_q    <= 8'h00;
            ctrl_q    <= 3'b000;
            prev_q    <= 8'h00;
            irq_q     <= 1'b0;
            state_q   <= ST_STRAP;
            cnt_q     <= 8'd0;
            pin_oe_q  <= 1'b1;
            pin_out_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            mask_q    <= mask_d;
            type_q    <= type_d;
            ctrl_q    <= ctrl_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pin_oe_q  <= pin_oe_d;
            pin_out_q <= pin_out_d;
        end
    end

    always_comb begin
        csr.csr_do = 8'h00;
        if (hit) begin
            case (offs)
                2'd0:    csr.csr_do = status_q;
                2'd1:    csr.csr_do = mask_q;
                2'd2:    csr.csr_do = type_q;
                default: csr.csr_do = {5'b00000, ctrl_q};
            endcase
        end
    end

    assign pin_oe      = pin_oe_q;
    assign pin_out     = pin_out_q;
    assign irq         = irq_q;
    assign dbg_state_o = state_q;

endmodule
